prompt_tuner: RTL and testbench
===============================

PROMPT_TUNER -- requirements
Module: prompt_tuner

Interface
REQ-001 Parameter NUM_STAGES, default 2, number of tuning stages (1..8); stage 0 is the motion stage, stages 1..NUM_STAGES-1 are detail stages.
REQ-002 Parameter W, default 8, width of scores, targets and prompt parameters.
REQ-003 Parameter STEP, default 1, adjust step per iteration.
REQ-004 Parameter TOL, default 0, accept band: stage converges when |score - target| <= TOL.
REQ-005 Parameter MAX_ITER, default 64, adjusts allowed per stage before failure.
REQ-006 Parameters TARGET0 = 100, INIT0 = 50, INITK = 150, AIM_T0/T1/T2 = 30/45/60: stage-0 target, stage-0 initial prompt, detail-stage initial prompt, and detail targets for aim 001/010/100.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 start  input  1  begin a tuning run; sampled only in IDLE, DONE or FAIL.
REQ-010 aim  input  3  one-hot detail-target select; latched on accepted start.
REQ-011 score  input  W  evaluator score for the current stage.
REQ-012 score_valid  input  1  score qualifier; sampled only in WAIT.
REQ-013 make  output  1  one-cycle pulse: generate with current prompt.
REQ-014 check  output  1  one-cycle pulse: request evaluation.
REQ-015 stage_idx  output  clog2(NUM_STAGES) (min 1)  stage being tuned.
REQ-016 prmt  output  NUM_STAGES*W  all prompt parameters, stage k at bits [k*W +: W].
REQ-017 make_video  output  1  one-cycle pulse after final stage converges.
REQ-018 busy / done / fail  output  1 each  run active / completed (level) / aborted (level).

Function
REQ-019 States SHALL be IDLE, MAKE, CHECK, WAIT, ADJUST, NEXT, VIDEO, DONE, FAIL; registered state, no combinational latches on outputs.
REQ-020 IDLE/DONE/FAIL + start: if NUM_STAGES>1 and aim not one-hot -> FAIL; else latch aim, load prmt (stage0=INIT0, others=INITK), stage_idx=0, iter=0, clear done/fail, -> MAKE.
REQ-021 MAKE: make=1 for exactly that cycle -> CHECK; CHECK: check=1 for exactly that cycle -> WAIT.
REQ-022 WAIT: hold until score_valid=1; then converged -> NEXT, else -> ADJUST; no timeout while waiting.
REQ-023 Target: stage 0 = TARGET0; stage k>0 = AIM_T0/T1/T2 per latched aim.
REQ-024 Compare in W+1 bits, unsigned; no wrap in |score - target|.
REQ-025 ADJUST: if iter == MAX_ITER -> FAIL without changing prmt; else prmt[stage] += STEP if score<target, -= STEP if score>target, saturating at 2^W-1 and 0; iter++ -> MAKE.
REQ-026 NEXT: last stage -> VIDEO; else stage_idx++, iter=0 -> MAKE.
REQ-027 VIDEO: make_video=1 one cycle -> DONE; DONE holds done=1, FAIL holds fail=1, until accepted start or rst.
REQ-028 busy=1 in all states except IDLE, DONE, FAIL; start while busy ignored; score_valid outside WAIT ignored.
REQ-029 Latency per non-converging iteration: 4 cycles + score wait (MAKE, CHECK, WAIT>=1, ADJUST).
REQ-030 prmt retains final values in DONE/FAIL until next accepted start.

Reset
REQ-031 rst=1 at any edge, including mid-run, SHALL force IDLE; make, check, make_video, busy, done, fail = 0; stage_idx=0; iter=0; prmt stage0=INIT0, others=INITK; latched aim=0; rst overrides start.

Verification
REQ-032 Defaults, aim=001; stage0 scores 98, 98, 100; stage1 score 30 -> prmt0 50->51->52, prmt1=150, one make_video pulse, done=1, make pulsed 4 times.
REQ-033 Stage1 score 200 then 30 -> prmt1 150->149, then converge; each make/check pulse exactly one cycle.
REQ-034 STEP=100, stage1 scores 0, 0, 60 with aim=100 -> prmt1 150->250->255 (saturated), then done.
REQ-035 Stage0 score always 0 -> fail=1 after 64 adjusts, prmt0=114, no make_video.
REQ-036 start with aim=011 -> fail=1 next cycle, no make pulse; then start with aim=010 -> run proceeds, fail clears.
REQ-037 rst asserted in WAIT of stage1 -> next cycle all outputs at reset values; score_valid during rst ignored.

Source files
------------

// File: rtl/prompt_tuner.sv
// Iterative prompt tuner: per stage, generate/evaluate/adjust until the score hits its target, then emit a video pulse.
// Latency: 4 cycles + score wait per adjust iteration; the run stalls indefinitely in WAIT until score_valid.
module prompt_tuner #(
    parameter int NUM_STAGES = 2,
    parameter int W          = 8,
    parameter int STEP       = 1,
    parameter int TOL        = 0,
    parameter int MAX_ITER   = 64,
    parameter int TARGET0    = 100,
    parameter int INIT0      = 50,
    parameter int INITK      = 150,
    parameter int AIM_T0     = 30,
    parameter int AIM_T1     = 45,
    parameter int AIM_T2     = 60,
    localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              aim,
    input  logic [W-1:0]            score,
    input  logic                    score_valid,
    output logic                    make,
    output logic                    check,
    output logic [SW-1:0]           stage_idx,
    output logic [NUM_STAGES*W-1:0] prmt,
    output logic                    make_video,
    output logic                    busy,
    output logic                    done,
    output logic                    fail
);
    localparam int IW = $clog2(MAX_ITER + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_MAKE, S_CHECK, S_WAIT, S_ADJUST, S_NEXT, S_VIDEO, S_DONE, S_FAIL
    } state_t;

    state_t        state;
    logic [IW-1:0] iter;
    logic [2:0]    aim_q;
    logic          lt, gt;

    logic [W:0]    tgt, s_ext, diff, inc;
    logic [W-1:0]  cur, up, dn, adj;
    logic          conv;

    function automatic logic [NUM_STAGES*W-1:0] init_prmt();
        logic [NUM_STAGES*W-1:0] r;
        for (int k = 0; k < NUM_STAGES; k++)
            r[k*W +: W] = (k == 0) ? W'(INIT0) : W'(INITK);
        return r;
    endfunction

    always_comb begin
        tgt = (W+1)'(TARGET0);
        if (stage_idx != '0) begin
            if (aim_q[0])      tgt = (W+1)'(AIM_T0);
            else if (aim_q[1]) tgt = (W+1)'(AIM_T1);
            else if (aim_q[2]) tgt = (W+1)'(AIM_T2);
        end
        // Extra bit keeps the distance exact for any score/target pair.
        s_ext = {1'b0, score};
        diff  = (s_ext >= tgt) ? s_ext - tgt : tgt - s_ext;
        conv  = (diff <= (W+1)'(TOL));

        cur = prmt[int'(stage_idx)*W +: W];
        inc = {1'b0, cur} + (W+1)'(STEP);
        up  = inc[W] ? '1 : inc[W-1:0];
        dn  = ({1'b0, cur} >= (W+1)'(STEP)) ? cur - W'(STEP) : '0;
        adj = lt ? up : (gt ? dn : cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            make       <= 1'b0;
            check      <= 1'b0;
            make_video <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            stage_idx  <= '0;
            iter       <= '0;
            prmt       <= init_prmt();
            aim_q      <= '0;
            lt         <= 1'b0;
            gt         <= 1'b0;
        end else begin
            make       <= 1'b0;
            check      <= 1'b0;
            make_video <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        done <= 1'b0;
                        if (NUM_STAGES > 1 && !$onehot(aim)) begin
                            fail  <= 1'b1;
                            state <= S_FAIL;
                        end else begin
                            fail      <= 1'b0;
                            aim_q     <= aim;
                            prmt      <= init_prmt();
                            stage_idx <= '0;
                            iter      <= '0;
                            busy      <= 1'b1;
                            make      <= 1'b1;
                            state     <= S_MAKE;
                        end
                    end
                end
                S_MAKE: begin
                    check <= 1'b1;
                    state <= S_CHECK;
                end
                S_CHECK: state <= S_WAIT;
                S_WAIT: begin
                    if (score_valid) begin
                        lt    <= (s_ext < tgt);
                        gt    <= (s_ext > tgt);
                        state <= conv ? S_NEXT : S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    if (iter == IW'(MAX_ITER)) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end else begin
                        prmt[int'(stage_idx)*W +: W] <= adj;
                        iter  <= iter + 1'b1;
                        make  <= 1'b1;
                        state <= S_MAKE;
                    end
                end
                S_NEXT: begin
                    if (stage_idx == SW'(NUM_STAGES - 1)) begin
                        make_video <= 1'b1;
                        state      <= S_VIDEO;
                    end else begin
                        stage_idx <= stage_idx + 1'b1;
                        iter      <= '0;
                        make      <= 1'b1;
                        state     <= S_MAKE;
                    end
                end
                S_VIDEO: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prompt_tuner.sv
// Drives two tuners (STEP=1 and STEP=100) with directed and random score streams against a stage/iteration reference model.
module tb_prompt_tuner;
    localparam int W = 8, NS = 2, MI = 64, TOL = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start_s [2];
    logic [2:0]       aim_s   [2];
    logic [W-1:0]     score_s [2];
    logic             sv_s    [2];
    logic             make_o  [2];
    logic             check_o [2];
    logic             mv_o    [2];
    logic             busy_o  [2];
    logic             done_o  [2];
    logic             fail_o  [2];
    logic [0:0]       stg_o   [2];
    logic [NS*W-1:0]  prmt_o  [2];

    int checks = 0, errors = 0;
    int mk_cnt[2] = '{0, 0};
    int mv_cnt[2] = '{0, 0};
    int stepv[2]  = '{1, 100};
    int sq[$];

    prompt_tuner dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .aim(aim_s[0]), .score(score_s[0]),
        .score_valid(sv_s[0]), .make(make_o[0]), .check(check_o[0]), .stage_idx(stg_o[0]),
        .prmt(prmt_o[0]), .make_video(mv_o[0]), .busy(busy_o[0]), .done(done_o[0]), .fail(fail_o[0])
    );
    prompt_tuner #(.STEP(100)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .aim(aim_s[1]), .score(score_s[1]),
        .score_valid(sv_s[1]), .make(make_o[1]), .check(check_o[1]), .stage_idx(stg_o[1]),
        .prmt(prmt_o[1]), .make_video(mv_o[1]), .busy(busy_o[1]), .done(done_o[1]), .fail(fail_o[1])
    );

    always @(posedge clk)
        for (int i = 0; i < 2; i++) begin
            if (make_o[i]) mk_cnt[i] <= mk_cnt[i] + 1;
            if (mv_o[i])   mv_cnt[i] <= mv_cnt[i] + 1;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int target_of(input int stage, input logic [2:0] a);
        if (stage == 0) return 100;
        if (a == 3'b001) return 30;
        if (a == 3'b010) return 45;
        return 60;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int rand_score(input int t);
        case ($urandom_range(0, 2))
            0:       return t;
            1:       return int'($urandom_range(0, 255));
            default: return clamp(t + int'($urandom_range(0, 6)) - 3);
        endcase
    endfunction

    task automatic chk_reset_outputs(input int d);
        chk("rst_make", make_o[d], 0);
        chk("rst_check", check_o[d], 0);
        chk("rst_video", mv_o[d], 0);
        chk("rst_busy", busy_o[d], 0);
        chk("rst_done", done_o[d], 0);
        chk("rst_fail", fail_o[d], 0);
        chk("rst_stage", stg_o[d], 0);
        chk("rst_prmt", prmt_o[d], {8'd150, 8'd50});
    endtask

    // One tuning run from an idle/done/fail state; abort_stage >= 0 asserts rst in that stage's WAIT.
    task automatic run(input int d, input logic [2:0] a, input int abort_stage);
        int p[2];
        int stage, iter, s, t, m0, v0, evals;
        bit fin;
        m0 = mk_cnt[d];
        v0 = mv_cnt[d];
        start_s[d] = 1'b1;
        aim_s[d]   = a;
        @(negedge clk);
        start_s[d] = 1'b0;
        if (!$onehot(a)) begin
            chk("bad_aim_fail", fail_o[d], 1);
            chk("bad_aim_busy", busy_o[d], 0);
            chk("bad_aim_done", done_o[d], 0);
            @(negedge clk);
            chk("bad_aim_makes", mk_cnt[d] - m0, 0);
            return;
        end
        p = '{50, 150};
        stage = 0; iter = 0; evals = 0; fin = 0;
        while (!fin) begin
            chk("make", make_o[d], 1);
            chk("check_early", check_o[d], 0);
            chk("busy", busy_o[d], 1);
            chk("done_low", done_o[d], 0);
            chk("fail_low", fail_o[d], 0);
            chk("stage_idx", stg_o[d], stage);
            chk("prmt0", prmt_o[d][7:0], p[0]);
            chk("prmt1", prmt_o[d][15:8], p[1]);
            sv_s[d]    = 1'($urandom_range(0, 1));
            score_s[d] = W'($urandom);
            @(negedge clk);
            sv_s[d] = 1'b0;
            chk("make_one_cycle", make_o[d], 0);
            chk("check", check_o[d], 1);
            start_s[d] = 1'($urandom_range(0, 1));
            aim_s[d]   = 3'b011;
            @(negedge clk);
            start_s[d] = 1'b0;
            chk("check_one_cycle", check_o[d], 0);
            chk("busy_wait", busy_o[d], 1);
            t = target_of(stage, a);
            if (stage == abort_stage) begin
                rst        = 1'b1;
                sv_s[d]    = 1'b1;
                score_s[d] = W'(t);
                @(negedge clk);
                rst     = 1'b0;
                sv_s[d] = 1'b0;
                chk_reset_outputs(d);
                @(negedge clk);
                chk("post_rst_busy", busy_o[d], 0);
                return;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            s = (sq.size() > 0) ? sq.pop_front() : rand_score(t);
            score_s[d] = W'(s);
            sv_s[d]    = 1'b1;
            evals++;
            @(negedge clk);
            sv_s[d]    = 1'b0;
            score_s[d] = W'($urandom);
            @(negedge clk);
            if ((s > t ? s - t : t - s) <= TOL) begin
                if (stage == NS - 1) begin
                    chk("video", mv_o[d], 1);
                    chk("busy_video", busy_o[d], 1);
                    @(negedge clk);
                    chk("video_one_cycle", mv_o[d], 0);
                    chk("done", done_o[d], 1);
                    chk("busy_done", busy_o[d], 0);
                    chk("fail_done", fail_o[d], 0);
                    chk("final_prmt", prmt_o[d], {p[1][7:0], p[0][7:0]});
                    fin = 1;
                end else begin
                    stage++;
                    iter = 0;
                end
            end else if (iter == MI) begin
                chk("fail", fail_o[d], 1);
                chk("busy_fail", busy_o[d], 0);
                chk("make_after_fail", make_o[d], 0);
                chk("fail_prmt", prmt_o[d], {p[1][7:0], p[0][7:0]});
                fin = 1;
            end else begin
                if (s < t) p[stage] = clamp(p[stage] + stepv[d]);
                else       p[stage] = clamp(p[stage] - stepv[d]);
                iter++;
            end
        end
        @(negedge clk);
        chk("make_count", mk_cnt[d] - m0, evals);
        chk("video_count", mv_cnt[d] - v0, fin && done_o[d] ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; aim_s[i] = 3'b000; score_s[i] = '0; sv_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        start_s[0] = 1'b1;
        aim_s[0]   = 3'b001;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);

        sq = '{98, 98, 100, 30};
        run(0, 3'b001, -1);
        sq = '{100, 200, 30};
        run(0, 3'b001, -1);
        sq = '{100, 0, 0, 60};
        run(1, 3'b100, -1);
        sq.delete();
        for (int i = 0; i < MI + 1; i++) sq.push_back(0);
        run(0, 3'b001, -1);
        chk("fail_prmt0_114", prmt_o[0][7:0], 114);
        run(0, 3'b011, -1);
        run(0, 3'b010, -1);
        run(0, 3'b001, 1);
        run(0, 3'b010, -1);

        for (int n = 0; n < 24; n++) begin
            int d;
            logic [2:0] a;
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
            run(d, a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
